// File: rtl/video_serial_receiver_if.sv
// Link bundle for the serial display receiver.
// Carries the 4-wire serial display link (hardware reset, select, cmd/data,
// serial clock, serial data) from the controller to the device. It also carries
// the decoded pixel-write and status outputs from the device back to the back end.
//   master : controller / back-end side (drives link inputs, observes outputs)
//   slave  : receiver side (observes link inputs, drives outputs)
interface video_serial_receiver_if #(
    parameter int PIXEL_BITS = 16,
    parameter int HCTR_BITS  = 7,
    parameter int VCTR_BITS  = 6
);
    logic                  in_vid_rst;
    logic                  in_vid_select;
    logic                  in_vid_cmd;
    logic                  in_vid_serial_clk;
    logic                  in_vid_serial;
    logic [PIXEL_BITS-1:0] out_pixel;
    logic [HCTR_BITS-1:0]  out_hpix;
    logic [VCTR_BITS-1:0]  out_vpix;
    logic                  out_pixel_we;
    logic                  out_frame_done;
    logic                  out_sleep;
    logic                  out_display_on;
    logic                  out_inverted;
    logic [7:0]            out_madctl;
    logic [7:0]            out_colmod;
    logic                  out_unknown_cmd;

    modport master (
        output in_vid_rst, in_vid_select, in_vid_cmd, in_vid_serial_clk, in_vid_serial,
        input  out_pixel, out_hpix, out_vpix, out_pixel_we, out_frame_done,
               out_sleep, out_display_on, out_inverted, out_madctl, out_colmod,
               out_unknown_cmd
    );

    modport slave (
        input  in_vid_rst, in_vid_select, in_vid_cmd, in_vid_serial_clk, in_vid_serial,
        output out_pixel, out_hpix, out_vpix, out_pixel_we, out_frame_done,
               out_sleep, out_display_on, out_inverted, out_madctl, out_colmod,
               out_unknown_cmd
    );
endinterface

// File: rtl/video_serial_receiver.sv
// Device end of the serial display link.
// Oversamples the link with in_clk and assembles MSB-first serial words. It then
// decodes the controller command subset and emits windowed pixel writes.
//   in_clk  : system clock (serial clock must be at most in_clk/4)
//   in_rst  : synchronous active-high reset
//   link    : slave side of video_serial_receiver_if (link inputs, pixel/status outputs)
module video_serial_receiver #(
    parameter int SERIAL_BITS   = 8,
    parameter int PIXEL_BITS    = 16,
    parameter int SCREEN_WIDTH  = 128,
    parameter int SCREEN_HEIGHT = 64,
    parameter int HCTR_BITS     = $clog2(SCREEN_WIDTH),
    parameter int VCTR_BITS     = $clog2(SCREEN_HEIGHT),
    parameter int SYNC_STAGES   = 2
) (
    input logic                    in_clk,
    input logic                    in_rst,
    video_serial_receiver_if.slave link
);

    localparam int          BCNT_BITS = $clog2(SERIAL_BITS);
    localparam logic [15:0] WIDTH16   = 16'(SCREEN_WIDTH);
    localparam logic [15:0] HEIGHT16  = 16'(SCREEN_HEIGHT);
    // Link bit positions inside the synchroniser vector; serial clock idles high.
    localparam logic [4:0]  SYNC_IDLE = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARAM  = 2'd1,
        ST_RAM_HI = 2'd2,
        ST_RAM_LO = 2'd3
    } state_t;

    // ---------------- synchroniser and edge detection ----------------
    logic [SYNC_STAGES-1:0][4:0] sync_r;
    logic                        sclk_prev_r;
    logic [4:0]                  raw_s;
    logic                        vid_rst_s, sel_s, cmd_s, sclk_s, dat_s, rise_s;

    assign raw_s     = {link.in_vid_rst, link.in_vid_select, link.in_vid_cmd,
                        link.in_vid_serial_clk, link.in_vid_serial};
    assign vid_rst_s = sync_r[SYNC_STAGES-1][4];
    assign sel_s     = sync_r[SYNC_STAGES-1][3];
    assign cmd_s     = sync_r[SYNC_STAGES-1][2];
    assign sclk_s    = sync_r[SYNC_STAGES-1][1];
    assign dat_s     = sync_r[SYNC_STAGES-1][0];
    assign rise_s    = sclk_s & ~sclk_prev_r;

    // Synchroniser chain on every link input plus serial clock history.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            sync_r      <= {SYNC_STAGES{SYNC_IDLE}};
            sclk_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], raw_s};
            sclk_prev_r <= sclk_s;
        end
    end

    // ---------------- word assembly ----------------
    logic [BCNT_BITS-1:0]   bit_cnt_r;
    logic [SERIAL_BITS-1:0] shift_r;
    logic [SERIAL_BITS-1:0] word_r;
    logic                   word_is_data_r;
    logic                   word_stb_r;

    // Bit capture: deselect discards a partial word; the 8th bit delivers a word.
    always_ff @(posedge in_clk) begin
        if (in_rst || vid_rst_s) begin
            bit_cnt_r      <= '0;
            shift_r        <= '0;
            word_r         <= '0;
            word_is_data_r <= 1'b0;
            word_stb_r     <= 1'b0;
        end else begin
            word_stb_r <= 1'b0;
            if (!sel_s) begin
                bit_cnt_r <= '0;
            end else if (rise_s) begin
                shift_r <= {shift_r[SERIAL_BITS-2:0], dat_s};
                if (bit_cnt_r == BCNT_BITS'(SERIAL_BITS - 1)) begin
                    bit_cnt_r      <= '0;
                    word_r         <= {shift_r[SERIAL_BITS-2:0], dat_s};
                    word_is_data_r <= cmd_s;
                    word_stb_r     <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + BCNT_BITS'(1);
                end
            end
        end
    end

    // ---------------- command decoder FSM ----------------
    state_t                 state_r, state_next;
    logic [1:0]             idx_r, idx_next;
    logic [SERIAL_BITS-1:0] pcmd_r, pcmd_next;
    logic soft_rst_s, unknown_s, ram_start_s, hi_s, pixel_s, param_s;
    logic sleep_clr_s, disp_on_s, inv_set_s, inv_clr_s, multi_s;

    // Window commands take four parameter bytes; the others take one.
    assign multi_s = (pcmd_r == 8'h2a) || (pcmd_r == 8'h2b);

    // Decoder state register.
    always_ff @(posedge in_clk) begin
        if (in_rst || vid_rst_s) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            pcmd_r  <= '0;
        end else begin
            state_r <= state_next;
            idx_r   <= idx_next;
            pcmd_r  <= pcmd_next;
        end
    end

    // Next-state and action decode; a command word always restarts the sequence.
    always_comb begin
        state_next  = state_r;
        idx_next    = idx_r;
        pcmd_next   = pcmd_r;
        soft_rst_s  = 1'b0;
        unknown_s   = 1'b0;
        ram_start_s = 1'b0;
        hi_s        = 1'b0;
        pixel_s     = 1'b0;
        param_s     = 1'b0;
        sleep_clr_s = 1'b0;
        disp_on_s   = 1'b0;
        inv_set_s   = 1'b0;
        inv_clr_s   = 1'b0;
        if (word_stb_r && !word_is_data_r) begin
            state_next = ST_IDLE;
            case (word_r)
                8'h2a, 8'h2b, 8'h36, 8'h3a: begin
                    state_next = ST_PARAM;
                    idx_next   = 2'd0;
                    pcmd_next  = word_r;
                end
                8'h2c: begin
                    state_next  = ST_RAM_HI;
                    ram_start_s = 1'b1;
                end
                8'h11:   sleep_clr_s = 1'b1;
                8'h20:   inv_clr_s   = 1'b1;
                8'h21:   inv_set_s   = 1'b1;
                8'h29:   disp_on_s   = 1'b1;
                8'h01:   soft_rst_s  = 1'b1;
                default: unknown_s   = 1'b1;
            endcase
        end else if (word_stb_r) begin
            case (state_r)
                ST_PARAM: begin
                    param_s = 1'b1;
                    if (multi_s && (idx_r != 2'd3)) begin
                        idx_next = idx_r + 2'd1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_RAM_HI: begin
                    hi_s       = 1'b1;
                    state_next = ST_RAM_LO;
                end
                ST_RAM_LO: begin
                    pixel_s    = 1'b1;
                    state_next = ST_RAM_HI;
                end
                default: state_next = ST_IDLE;
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // ---------------- datapath ----------------
    logic [15:0] x_start_r, x_end_r, y_start_r, y_end_r;
    logic [15:0] stage_start_r, stage_end_r;
    logic [15:0] cur_x_r, cur_y_r;
    logic [SERIAL_BITS-1:0] hi_r;
    logic [PIXEL_BITS-1:0]  pixel_r;
    logic [HCTR_BITS-1:0]   hpix_r;
    logic [VCTR_BITS-1:0]   vpix_r;
    logic pixel_we_r, frame_done_r, sleep_r, display_on_r, inverted_r, unknown_r;
    logic [7:0] madctl_r, colmod_r;
    logic x_last_s, y_last_s, on_screen_s;

    assign x_last_s    = (cur_x_r == x_end_r);
    assign y_last_s    = (cur_y_r == y_end_r);
    assign on_screen_s = (cur_x_r < WIDTH16) && (cur_y_r < HEIGHT16);

    // Window, cursor, flags and pixel output registers.
    always_ff @(posedge in_clk) begin
        if (in_rst || vid_rst_s || soft_rst_s) begin
            x_start_r     <= 16'd0;
            x_end_r       <= WIDTH16 - 16'd1;
            y_start_r     <= 16'd0;
            y_end_r       <= HEIGHT16 - 16'd1;
            stage_start_r <= 16'd0;
            stage_end_r   <= 16'd0;
            cur_x_r       <= 16'd0;
            cur_y_r       <= 16'd0;
            hi_r          <= '0;
            pixel_r       <= '0;
            hpix_r        <= '0;
            vpix_r        <= '0;
            pixel_we_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            sleep_r       <= 1'b1;
            display_on_r  <= 1'b0;
            inverted_r    <= 1'b0;
            unknown_r     <= 1'b0;
            madctl_r      <= 8'd0;
            colmod_r      <= 8'd0;
        end else begin
            pixel_we_r   <= 1'b0;
            frame_done_r <= 1'b0;
            unknown_r    <= unknown_s;
            if (sleep_clr_s) sleep_r      <= 1'b0;
            if (disp_on_s)   display_on_r <= 1'b1;
            if (inv_set_s)   inverted_r   <= 1'b1;
            if (inv_clr_s)   inverted_r   <= 1'b0;
            if (ram_start_s) begin
                cur_x_r <= x_start_r;
                cur_y_r <= y_start_r;
            end
            if (hi_s) hi_r <= word_r;
            if (param_s) begin
                case (pcmd_r)
                    8'h36: madctl_r <= word_r;
                    8'h3a: colmod_r <= word_r;
                    default: begin
                        // Window bytes are staged; the live window changes only on the 4th.
                        case (idx_r)
                            2'd0:    stage_start_r[15:8] <= word_r;
                            2'd1:    stage_start_r[7:0]  <= word_r;
                            2'd2:    stage_end_r[15:8]   <= word_r;
                            default: begin
                                if (pcmd_r == 8'h2a) begin
                                    x_start_r <= stage_start_r;
                                    x_end_r   <= {stage_end_r[15:8], word_r};
                                end else begin
                                    y_start_r <= stage_start_r;
                                    y_end_r   <= {stage_end_r[15:8], word_r};
                                end
                            end
                        endcase
                    end
                endcase
            end
            if (pixel_s) begin
                pixel_r      <= {hi_r, word_r};
                hpix_r       <= cur_x_r[HCTR_BITS-1:0];
                vpix_r       <= cur_y_r[VCTR_BITS-1:0];
                pixel_we_r   <= on_screen_s;
                frame_done_r <= on_screen_s && x_last_s && y_last_s;
                // Cursor keeps advancing even for clipped pixels; 16-bit wrap is intended.
                if (x_last_s) begin
                    cur_x_r <= x_start_r;
                    cur_y_r <= y_last_s ? y_start_r : (cur_y_r + 16'd1);
                end else begin
                    cur_x_r <= cur_x_r + 16'd1;
                end
            end
        end
    end

    assign link.out_pixel       = pixel_r;
    assign link.out_hpix        = hpix_r;
    assign link.out_vpix        = vpix_r;
    assign link.out_pixel_we    = pixel_we_r;
    assign link.out_frame_done  = frame_done_r;
    assign link.out_sleep       = sleep_r;
    assign link.out_display_on  = display_on_r;
    assign link.out_inverted    = inverted_r;
    assign link.out_madctl      = madctl_r;
    assign link.out_colmod      = colmod_r;
    assign link.out_unknown_cmd = unknown_r;

endmodule

// File: tb/tb_video_serial_receiver.sv
// Self-checking bench for video_serial_receiver.
// Uses a reduced screen so that a full frame stays short. A transaction-level
// model consumes the word stream and queues the expected pixel writes. One
// compare process checks every write strobe against that queue.
module tb_video_serial_receiver;

    localparam int TB_W = 32;
    localparam int TB_H = 8;
    localparam int HB   = $clog2(TB_W);
    localparam int VB   = $clog2(TB_H);

    logic clk;
    logic in_rst;

    video_serial_receiver_if #(.PIXEL_BITS(16), .HCTR_BITS(HB), .VCTR_BITS(VB)) vif ();

    video_serial_receiver #(
        .SERIAL_BITS(8), .PIXEL_BITS(16), .SCREEN_WIDTH(TB_W), .SCREEN_HEIGHT(TB_H),
        .HCTR_BITS(HB), .VCTR_BITS(VB), .SYNC_STAGES(2)
    ) dut (
        .in_clk (clk),
        .in_rst (in_rst),
        .link   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] pix;
        logic        fd;
    } wr_t;

    wr_t exp_q[$];

    // mode: 0 idle, 1 collecting parameters, 2 expecting high byte, 3 expecting low byte
    int          m_mode;
    logic [7:0]  m_pcmd;
    int          m_pidx;
    logic [7:0]  m_pb[4];
    logic [15:0] m_xs, m_xe, m_ys, m_ye, m_cx, m_cy;
    logic [7:0]  m_hi, m_madctl, m_colmod;
    logic        m_sleep, m_disp, m_inv;
    int          m_unknown;

    task automatic model_reset();
        m_mode = 0; m_pcmd = 8'h00; m_pidx = 0;
        m_xs = 16'd0; m_xe = 16'(TB_W - 1); m_ys = 16'd0; m_ye = 16'(TB_H - 1);
        m_cx = 16'd0; m_cy = 16'd0; m_hi = 8'h00;
        m_madctl = 8'h00; m_colmod = 8'h00;
        m_sleep = 1'b1; m_disp = 1'b0; m_inv = 1'b0;
    endtask

    task automatic model_word(input logic is_data, input logic [7:0] b);
        wr_t w;
        if (!is_data) begin
            m_mode = 0;
            case (b)
                8'h2a, 8'h2b, 8'h36, 8'h3a: begin m_mode = 1; m_pcmd = b; m_pidx = 0; end
                8'h2c: begin m_cx = m_xs; m_cy = m_ys; m_mode = 2; end
                8'h11: m_sleep = 1'b0;
                8'h20: m_inv = 1'b0;
                8'h21: m_inv = 1'b1;
                8'h29: m_disp = 1'b1;
                8'h01: model_reset();
                default: m_unknown++;
            endcase
        end else if (m_mode == 1) begin
            if (m_pcmd == 8'h36) begin m_madctl = b; m_mode = 0; end
            else if (m_pcmd == 8'h3a) begin m_colmod = b; m_mode = 0; end
            else begin
                m_pb[m_pidx] = b;
                if (m_pidx == 3) begin
                    if (m_pcmd == 8'h2a) begin m_xs = {m_pb[0], m_pb[1]}; m_xe = {m_pb[2], m_pb[3]}; end
                    else begin m_ys = {m_pb[0], m_pb[1]}; m_ye = {m_pb[2], m_pb[3]}; end
                    m_mode = 0;
                end else begin
                    m_pidx++;
                end
            end
        end else if (m_mode == 2) begin
            m_hi = b; m_mode = 3;
        end else if (m_mode == 3) begin
            w.x = m_cx; w.y = m_cy; w.pix = {m_hi, b};
            w.fd = (m_cx == m_xe) && (m_cy == m_ye);
            if (m_cx < 16'(TB_W) && m_cy < 16'(TB_H)) exp_q.push_back(w);
            if (m_cx == m_xe) begin
                m_cx = m_xs;
                m_cy = (m_cy == m_ye) ? m_ys : m_cy + 16'd1;
            end else begin
                m_cx = m_cx + 16'd1;
            end
            m_mode = 2;
        end
    endtask

    // ---------------- compare process ----------------
    int          wr_count    = 0;
    int          dut_unknown = 0;
    logic [15:0] last_x, last_y, last_pix;
    logic        last_fd;

    always @(negedge clk) begin
        if (!in_rst) begin
            if (vif.out_unknown_cmd) dut_unknown++;
            if (vif.out_frame_done && !vif.out_pixel_we) chk("frame_done_without_write", 64'd1, 64'd0);
            if (vif.out_pixel_we) begin
                wr_t e, a;
                wr_count++;
                a.x = 16'(vif.out_hpix); a.y = 16'(vif.out_vpix);
                a.pix = vif.out_pixel; a.fd = vif.out_frame_done;
                last_x = a.x; last_y = a.y; last_pix = a.pix; last_fd = a.fd;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(a), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_write", 64'(a), 64'(e));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bits(input logic is_data, input logic [7:0] b, input int n);
        vif.in_vid_select = 1'b1;
        vif.in_vid_cmd    = is_data;
        for (int i = 7; i > 7 - n; i--) begin
            vif.in_vid_serial_clk = 1'b0;
            vif.in_vid_serial     = b[i];
            #20;
            vif.in_vid_serial_clk = 1'b1;
            if (i == 0) model_word(is_data, b);
            #20;
        end
    endtask

    task automatic send_word(input logic is_data, input logic [7:0] b);
        send_bits(is_data, b, 8);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_word(1'b0, b);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_word(1'b1, b);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_data(p[15:8]);
        send_data(p[7:0]);
    endtask

    task automatic deselect();
        vif.in_vid_select = 1'b0;
        #60;
    endtask

    task automatic check_state(input string nm);
        #100;
        chk({nm, "_sleep"},   64'(vif.out_sleep),      64'(m_sleep));
        chk({nm, "_display"}, 64'(vif.out_display_on), 64'(m_disp));
        chk({nm, "_invert"},  64'(vif.out_inverted),   64'(m_inv));
        chk({nm, "_madctl"},  64'(vif.out_madctl),     64'(m_madctl));
        chk({nm, "_colmod"},  64'(vif.out_colmod),     64'(m_colmod));
        chk({nm, "_unknown"}, 64'(dut_unknown),        64'(m_unknown));
        chk({nm, "_pending"}, 64'(exp_q.size()),       64'd0);
    endtask

    int base, ubase, r;
    logic [7:0] cmd_tab[12];

    initial begin
        cmd_tab = '{8'h2a, 8'h2b, 8'h36, 8'h3a, 8'h2c, 8'h2c, 8'h11, 8'h20, 8'h21, 8'h29, 8'h01, 8'hb2};
        vif.in_vid_rst = 1'b0; vif.in_vid_select = 1'b0; vif.in_vid_cmd = 1'b0;
        vif.in_vid_serial_clk = 1'b1; vif.in_vid_serial = 1'b0;
        m_unknown = 0;
        model_reset();
        in_rst = 1'b1;
        #100;
        in_rst = 1'b0;

        // Reset state.
        chk("rst_sleep",   64'(vif.out_sleep),       64'd1);
        chk("rst_display", 64'(vif.out_display_on),  64'd0);
        chk("rst_invert",  64'(vif.out_inverted),    64'd0);
        chk("rst_we",      64'(vif.out_pixel_we),    64'd0);
        chk("rst_pixel",   64'(vif.out_pixel),       64'd0);
        chk("rst_madctl",  64'(vif.out_madctl),      64'd0);

        // Flag commands.
        send_cmd(8'h11); send_cmd(8'h29); send_cmd(8'h21);
        check_state("flags");
        chk("flags_lit", 64'({vif.out_sleep, vif.out_display_on, vif.out_inverted}), 64'(3'b011));
        chk("flags_no_writes", 64'(wr_count), 64'd0);

        // Small window of two pixels.
        base = wr_count;
        send_cmd(8'h2a); send_data(8'h00); send_data(8'h02); send_data(8'h00); send_data(8'h03);
        send_cmd(8'h2b); send_data(8'h00); send_data(8'h01); send_data(8'h00); send_data(8'h01);
        send_cmd(8'h2c); send_pixel(16'hF800); send_pixel(16'h07E0);
        check_state("window");
        chk("window_count", 64'(wr_count - base), 64'd2);
        chk("window_last", 64'({last_x, last_y, last_pix, last_fd}), {15'd0, 16'd3, 16'd1, 16'h07E0, 1'b1});

        // Full frame on the default window, then wrap to the origin.
        send_cmd(8'h01);
        send_cmd(8'h2c);
        base = wr_count;
        for (int i = 0; i < TB_W * TB_H; i++) send_pixel(16'($urandom));
        check_state("frame");
        chk("frame_count", 64'(wr_count - base), 64'(TB_W * TB_H));
        chk("frame_last", 64'({last_x, last_y, last_fd}), {15'd0, 16'(TB_W - 1), 16'(TB_H - 1), 1'b1});
        send_pixel(16'h1234);
        check_state("wrap");
        chk("wrap_pos", 64'({last_x, last_y, last_pix}), {16'd0, 16'd0, 16'd0, 16'h1234});

        // Aborted window command leaves the window intact; wide window clips.
        send_cmd(8'h2a); send_data(8'h00); send_data(8'h10);
        send_cmd(8'h2c); send_pixel(16'hABCD);
        check_state("abort");
        chk("abort_pos", 64'({last_x, last_y, last_pix}), {16'd0, 16'd0, 16'd0, 16'hABCD});
        send_cmd(8'h2a); send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'hC8);
        send_cmd(8'h2c);
        base = wr_count;
        for (int i = 0; i < 200; i++) send_pixel(16'($urandom));
        check_state("clip");
        chk("clip_count", 64'(wr_count - base), 64'(TB_W));
        chk("clip_last", 64'({last_x, last_y}), {32'd0, 16'(TB_W - 1), 16'd0});

        // Partial word discarded, then link reset in the middle of a pixel.
        send_bits(1'b0, 8'h3a, 5); deselect();
        send_cmd(8'h3a); send_data(8'h55);
        check_state("partial");
        chk("partial_colmod", 64'(vif.out_colmod), 64'h55);
        send_cmd(8'h2a); send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h06);
        send_cmd(8'h2c); send_data(8'h99); send_bits(1'b1, 8'h77, 4);
        base = wr_count;
        vif.in_vid_select = 1'b0;
        vif.in_vid_rst = 1'b1; model_reset(); #60; vif.in_vid_rst = 1'b0; #60;
        check_state("vidrst");
        chk("vidrst_no_write", 64'(wr_count - base), 64'd0);
        chk("vidrst_sleep", 64'(vif.out_sleep), 64'd1);
        send_cmd(8'h2c); send_pixel(16'h0F0F);
        check_state("vidrst_win");
        chk("vidrst_win_pos", 64'({last_x, last_y}), 64'd0);

        // Unsupported command, then orphan data words.
        ubase = dut_unknown; base = wr_count;
        send_cmd(8'hB2); send_data(8'h11); send_data(8'h22); send_data(8'h33);
        check_state("unknown");
        chk("unknown_pulses", 64'(dut_unknown - ubase), 64'd1);
        chk("unknown_no_write", 64'(wr_count - base), 64'd0);

        // Randomised word stream.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7)); deselect();
            end else if (r < 18) begin
                send_cmd(cmd_tab[$urandom_range(0, 11)]);
            end else if (m_mode == 1 && (m_pcmd == 8'h2a || m_pcmd == 8'h2b)) begin
                send_data((m_pidx % 2 == 0) ? 8'h00 : 8'($urandom_range(0, TB_W + 4)));
            end else begin
                send_data(8'($urandom));
            end
        end
        deselect();
        check_state("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_serial_receiver.md
Name: video_serial_receiver

Overview:
- SPI-style display responder: the device end of the 4-wire serial display link (reset, select, cmd/data, serial clock, serial data) driven by the team's serial display controller.
- Oversamples the link with the system clock, assembles bytes and decodes the controller command subset: 0x01, 0x11, 0x20, 0x21, 0x29, 0x2a, 0x2b, 0x2c, 0x36, 0x3a.
- Emits windowed pixel writes (x, y, colour) for a framebuffer or parallel-display back end.
- Used as an on-chip display emulator for loopback verification and as a bridge to non-serial panels.

Parameters:
- SERIAL_BITS, 8, bits per serial word.
- PIXEL_BITS, 16, pixel width; two serial words per pixel, high byte first.
- SCREEN_WIDTH, 128, horizontal pixels accepted.
- SCREEN_HEIGHT, 64, vertical pixels accepted.
- HCTR_BITS, $clog2(SCREEN_WIDTH), x output width.
- VCTR_BITS, $clog2(SCREEN_HEIGHT), y output width.
- SYNC_STAGES, 2, synchroniser flip-flops on every link input.

Ports:
- in_clk  input  1  system clock; serial clock must be ≤ in_clk/4.
- in_rst  input  1  reset, synchronous, active-high.
- in_vid_rst  input  1  link hardware reset, active-high.
- in_vid_select  input  1  chip select, active-high: 1 = word transfer in progress.
- in_vid_cmd  input  1  0 = command word, 1 = data word.
- in_vid_serial_clk  input  1  serial clock, idle high.
- in_vid_serial  input  1  serial data, MSB first.
- out_pixel  output  PIXEL_BITS  pixel colour.
- out_hpix  output  HCTR_BITS  pixel x.
- out_vpix  output  VCTR_BITS  pixel y.
- out_pixel_we  output  1  one-cycle pixel write strobe.
- out_frame_done  output  1  one-cycle pulse when the window's last pixel is written.
- out_sleep  output  1  1 = sleep, cleared by 0x11.
- out_display_on  output  1  set by 0x29.
- out_inverted  output  1  0x21 sets, 0x20 clears.
- out_madctl  output  8  last 0x36 parameter.
- out_colmod  output  8  last 0x3a parameter.
- out_unknown_cmd  output  1  one-cycle pulse on an unsupported command byte.

Behaviour:
- Reset: in_rst=1, sampled on a rising in_clk edge, sets all outputs to 0 except out_sleep=1, and sets window x 0..SCREEN_WIDTH-1, y 0..SCREEN_HEIGHT-1.
  - Synchronised in_vid_rst=1 and a decoded 0x01 command have the same effect on the registers.
- Bit capture:
  - Link inputs pass through SYNC_STAGES flip-flops.
  - A bit is sampled on each synchronised rising edge of the serial clock while synchronised select=1.
  - in_vid_cmd is latched with the 8th bit.
  - Select=0 clears the bit counter, discarding a partial word, but does not clear the pixel byte phase or the parameter index.
- Word strobe: asserted one cycle after the synchronised 8th rising edge.
  - out_pixel_we follows the word strobe by one cycle, i.e. SYNC_STAGES+2 in_clk cycles after the raw 16th rising edge of a pixel.
- Decoder states:
  - Idle.
  - Param(cmd, idx 0..3).
  - RamHi, RamLo.
- A command word from any state aborts the current sequence, then decodes:
  - 0x2a/0x2b → Param, 4 bytes: start_hi, start_lo, end_hi, end_lo, staged in 16-bit registers. Committed only when the 4th byte is received; an aborted sequence leaves the old window unchanged.
  - 0x36/0x3a → Param, 1 byte → out_madctl/out_colmod.
  - 0x2c → cursor = (x_start, y_start), state RamHi.
  - 0x11, 0x20, 0x21, 0x29 → update their flags, state Idle.
  - 0x01 → soft reset.
  - Any other command → out_unknown_cmd pulse, state Idle.
- Data words:
  - In Idle, or in Param after its last byte, data words are ignored.
  - RamHi stores the high byte → RamLo. RamLo forms the pixel, issues the write, → RamHi.
- Cursor advance after each pixel:
  - x==x_end: x=x_start; y = (y==y_end) ? y_start : y+1.
  - x==x_end and y==y_end together: out_frame_done pulses in the same cycle as out_pixel_we.
  - Otherwise x+1.
  - The cursor is 16 bits, compared for equality and wrapping modulo 2^16.
  - If x_end<x_start, x counts up through 0xFFFF and wraps to 0 until it reaches x_end; y likewise.
- Clipping: the write strobe is suppressed when the cursor x≥SCREEN_WIDTH or y≥SCREEN_HEIGHT; the cursor still advances.
  - out_hpix/out_vpix carry the low bits of the cursor.
- No pixel writes occur while out_sleep=1 is irrelevant: writes occur regardless of the sleep and display flags.

Test Plan:
- Reset, then send 0x11, 0x29, 0x21 → out_sleep=0, out_display_on=1, out_inverted=1; out_pixel_we never asserted.
- Send 0x2a 00 02 00 03, 0x2b 00 01 00 01, 0x2c, then pixels 0xF800, 0x07E0 → writes (2,1,F800), (3,1,07E0) with out_frame_done on the second write.
- Full 128×64 frame after the default window → 8192 strobes; the last write is (127,63) with out_frame_done; the next pixel without 0x2c goes to (0,0).
- Send 0x2a 00 10, then command 0x2c, then one pixel → window unchanged, write at (0,0); then 0x2a 00 00 00 C8 with a 200-pixel burst on row 0 → exactly 128 strobes, x 0..127.
- Drop select after 5 bits, then send a full 0x3a 0x55 → out_colmod=0x55; inject in_vid_rst mid-pixel → out_sleep=1, window restored, out_pixel_we stays 0.
- Send unsupported command 0xB2 → one out_unknown_cmd pulse; following data words produce no writes.
